// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
// Accepts bitstream words over a valid/ready stream, serialises them LSB-first
// into the CCFF configuration chain, and counts exactly CHAIN_LEN shifted bits.
// Optional build macro CCFF_READBACK_EN adds a full-rotation CRC readback check
// (VERIFY state, err output). Without it, err is tied low and ccff_tail is unused.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count,
    output logic              err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
`ifdef CCFF_READBACK_EN
    localparam logic [2:0] S_VERIFY = 3'd4;
`endif

    localparam int              WL_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
    localparam logic [WL_W-1:0]  WL_LOAD = WL_W'(WORD_W - 1);

    logic [2:0]        state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;     // bits of the current word not yet presented
    logic [WL_W-1:0]   wleft_q, wleft_d;   // how many of those remain
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              head_q, head_d;
    logic              sen_q, sen_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ready_c;
    logic              load_word;

`ifdef CCFF_READBACK_EN
    logic [15:0] crc_in_q, crc_in_d;       // CRC of bits written into the chain
    logic [15:0] crc_out_q, crc_out_d;     // CRC of bits read back from the tail

    // One bit of CRC-16-CCITT (poly 0x1021, MSB-first feedback)
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

    // Next-state, serialiser and counter logic for the load sequence
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        wleft_d   = wleft_q;
        cnt_d     = cnt_q;
        head_d    = head_q;
        sen_d     = 1'b0;
        done_d    = done_q;
        err_d     = err_q;
        ready_c   = 1'b0;
        load_word = 1'b0;
`ifdef CCFF_READBACK_EN
        crc_in_d  = crc_in_q;
        crc_out_d = crc_out_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
`ifdef CCFF_READBACK_EN
                    crc_in_d  = 16'hFFFF;
                    crc_out_d = 16'hFFFF;
`endif
                end
            end
            S_FETCH: begin
                ready_c = 1'b1;
                if (cfg_valid) load_word = 1'b1;
            end
            S_SHIFT: begin
                if (cnt_q == LEN_C) begin
                    // Whole chain written; leftover word bits are discarded.
`ifdef CCFF_READBACK_EN
                    state_d = S_VERIFY;
                    cnt_d   = '0;
`else
                    state_d = S_DONE;
                    done_d  = 1'b1;
`endif
                end else if (wleft_q != '0) begin
                    head_d  = sreg_q[0];
                    sreg_d  = sreg_q >> 1;
                    wleft_d = wleft_q - WL_W'(1);
                    sen_d   = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
`ifdef CCFF_READBACK_EN
                    crc_in_d = crc16_step(crc_in_q, sreg_q[0]);
`endif
                end else begin
                    // Last bit of this word on the pins: accept the next one
                    // now so the chain keeps shifting without a bubble.
                    ready_c = 1'b1;
                    if (cfg_valid) load_word = 1'b1;
                    else           state_d   = S_FETCH;
                end
            end
`ifdef CCFF_READBACK_EN
            S_VERIFY: begin
                cnt_d     = cnt_q + CNT_W'(1);
                crc_out_d = crc16_step(crc_out_q, ccff_tail);
                if (cnt_q == LEN_C - CNT_W'(1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = (crc16_step(crc_out_q, ccff_tail) != crc_in_q);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (load_word) begin
            state_d = S_SHIFT;
            head_d  = cfg_data[0];
            sreg_d  = cfg_data >> 1;
            wleft_d = WL_LOAD;
            sen_d   = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
`ifdef CCFF_READBACK_EN
            crc_in_d = crc16_step(crc_in_q, cfg_data[0]);
`endif
        end
    end

    // Control and output registers, synchronously cleared by pReset_n
    always_ff @(posedge prog_clk) begin
        if (!pReset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            head_q  <= 1'b0;
            sen_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            sen_q   <= sen_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Word shift register; always reloaded before use, so no reset needed
    always_ff @(posedge prog_clk) begin
        sreg_q  <= sreg_d;
        wleft_q <= wleft_d;
    end

`ifdef CCFF_READBACK_EN
    // CRC accumulators, re-seeded at every start
    always_ff @(posedge prog_clk) begin
        crc_in_q  <= crc_in_d;
        crc_out_q <= crc_out_d;
    end

    // VERIFY recirculates the tail straight into the head so a full rotation
    // of CHAIN_LEN shifts leaves the chain contents unchanged.
    assign ccff_head     = (state_q == S_VERIFY) ? ccff_tail : head_q;
    assign ccff_shift_en = (state_q == S_VERIFY) ? 1'b1 : sen_q;
    assign busy          = (state_q == S_FETCH) || (state_q == S_SHIFT) ||
                           (state_q == S_VERIFY);
`else
    assign ccff_head     = head_q;
    assign ccff_shift_en = sen_q;
    assign busy          = (state_q == S_FETCH) || (state_q == S_SHIFT);
`endif

    assign cfg_ready = ready_c;
    assign done      = done_q;
    assign err       = err_q;
    assign bit_count = cnt_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader, 20-bit chain with 8-bit words. Includes a
// behavioural chain model so the readback build can also be exercised.
module tb_ccff_chain_loader;

    localparam int CHAIN_LEN = 20;
    localparam int WORD_W    = 8;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
`ifdef CCFF_READBACK_EN
    localparam int TOTAL = 2 * CHAIN_LEN;
`else
    localparam int TOTAL = CHAIN_LEN;
`endif

    logic              clk = 1'b0;
    logic              pReset_n;
    logic              start;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              ccff_head;
    logic              ccff_shift_en;
    logic              ccff_tail;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  bit_count;
    logic              err;

    always #5 clk = ~clk;

    ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
        .prog_clk(clk), .pReset_n(pReset_n), .start(start),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en),
        .ccff_tail(ccff_tail), .busy(busy), .done(done),
        .bit_count(bit_count), .err(err)
    );

    // Physical chain model with optional stuck-at-0 on bit 5
    logic [CHAIN_LEN-1:0] chain;
    logic                 stuck5;
    always @(posedge clk) begin
        if (ccff_shift_en) begin
            chain <= {chain[CHAIN_LEN-2:0], ccff_head};
            if (stuck5) chain[5] <= 1'b0;
        end
    end
    assign ccff_tail = chain[CHAIN_LEN-1];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: expected serial stream derived from the words
    logic [WORD_W-1:0] exp_words [3];
    logic              cap [CHAIN_LEN];
    int                tot, hs_cnt, gap_cnt, done_rise;
    bit                model_on = 0;
    bit                done_due, prev_done, last_head;

    always @(negedge clk) begin
        if (model_on) begin
            if (cfg_valid && cfg_ready) hs_cnt++;
            if (done && !prev_done) done_rise++;
            if (done_due) begin
                check("done_after_last_shift", done, 1);
                check("count_at_done", bit_count, CHAIN_LEN);
                check("busy_low_at_done", busy, 0);
                done_due = 0;
            end else if (tot < TOTAL) begin
                check("done_low_during_load", done, 0);
            end
            if (ccff_shift_en) begin
                check("no_extra_shift", tot < TOTAL, 1);
                if (tot < CHAIN_LEN) begin
                    check("head_bit", ccff_head, exp_words[tot / WORD_W][tot % WORD_W]);
                    cap[tot] = ccff_head;
                    tot++;
                    check("bit_count_tracks", bit_count, tot);
                end else begin
                    tot++;
                end
                if (tot == TOTAL) done_due = 1;
            end else if (busy && tot > 0 && tot < CHAIN_LEN) begin
                gap_cnt++;
                check("head_held_in_stall", ccff_head, last_head);
            end
            if (cfg_ready)
                check("ready_only_when_word_needed",
                      (tot % WORD_W == 0) && (tot < CHAIN_LEN), 1);
            prev_done = done;
            last_head = ccff_head;
        end
    end

    task automatic arm(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
        exp_words = '{w0, w1, w2};
        tot = 0; hs_cnt = 0; gap_cnt = 0; done_rise = 0;
        done_due = 0; prev_done = 0; last_head = ccff_head;
        model_on = 1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input int stall);
        bit ok;
        if (stall > 0) begin
            cfg_valid = 1'b0;
            ok = 0;
            for (int i = 0; i < 200 && !ok; i++) begin
                @(negedge clk);
                if (cfg_ready) ok = 1;
            end
            repeat (stall) @(posedge clk);
            #1;
        end
        cfg_data  = w;
        cfg_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (cfg_ready) ok = 1;
        end
        if (!ok) check("handshake_timeout", 0, 1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_idx(input int n);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (tot >= n) break;
        end
        check("reached_bit_index", tot >= n, 1);
    endtask

    task automatic end_checks(input int exp_gap, input logic exp_err);
        bit seen;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("done_timeout", seen, 1);
        @(posedge clk); #1;
        check("handshakes", hs_cnt, 3);
        check("stall_cycles", gap_cnt, exp_gap);
        check("done_rises_once", done_rise, 1);
        check("total_shifts", tot, TOTAL);
        check("err_result", err, exp_err);
        check("final_bit_count", bit_count, CHAIN_LEN);
    endtask

    task automatic check_seq(input string name, input logic [CHAIN_LEN-1:0] want);
        logic [CHAIN_LEN-1:0] got;
        for (int i = 0; i < CHAIN_LEN; i++) got[i] = cap[i];
        check(name, got, want);
    endtask

    // Chain bit j holds stream bit CHAIN_LEN-1-j once the load is complete
    task automatic check_chain(input logic [CHAIN_LEN-1:0] want_seq);
        logic [CHAIN_LEN-1:0] want;
        for (int i = 0; i < CHAIN_LEN; i++) want[CHAIN_LEN-1-i] = want_seq[i];
        check("chain_contents", chain, want);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_head"}, ccff_head, 0);
        check({tag, "_shift_en"}, ccff_shift_en, 0);
        check({tag, "_ready"}, cfg_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_bit_count"}, bit_count, 0);
    endtask

    // Stream bit i = bit i; words A5, 3C, 0F(low nibble)
    localparam logic [CHAIN_LEN-1:0] SEQ_A = 20'hF3CA5;

    initial begin
        pReset_n = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        stuck5 = 1'b0; chain = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        pReset_n = 1'b1;
        @(posedge clk); #1;

        // Single clean load
        pulse_start();
        arm(8'hA5, 8'h3C, 8'h0F);
        send_word(8'hA5, 0);
        send_word(8'h3C, 0);
        send_word(8'h0F, 0);
        end_checks(0, 1'b0);
        check_seq("seq_clean", SEQ_A);
        check_chain(SEQ_A);

        // Words offered in DONE are not consumed
        cfg_data = 8'hFF; cfg_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ready_low_in_done", cfg_ready, 0);
            check("no_shift_in_done", ccff_shift_en, 0);
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        check("count_kept_in_done", bit_count, CHAIN_LEN);

        // Source stall of 5 cycles before word 2
        pulse_start();
        arm(8'hA5, 8'h3C, 8'h0F);
        send_word(8'hA5, 0);
        send_word(8'h3C, 5);
        send_word(8'h0F, 0);
        end_checks(5, 1'b0);
        check_seq("seq_stalled", SEQ_A);

        // Reset mid-load, then a full recovery load
        pulse_start();
        arm(8'hA5, 8'h3C, 8'h0F);
        send_word(8'hA5, 0);
        send_word(8'h3C, 0);
        wait_idx(10);
        model_on = 0;
        pReset_n = 1'b0;
        @(posedge clk); #1;
        check_zero("midload_reset");
        pReset_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset_busy", busy, 0);
        pulse_start();
        arm(8'hA5, 8'h3C, 8'h0F);
        send_word(8'hA5, 0);
        send_word(8'h3C, 0);
        send_word(8'h0F, 0);
        end_checks(0, 1'b0);
        check_seq("seq_after_reset", SEQ_A);
        check_chain(SEQ_A);

        // start while busy is ignored
        pulse_start();
        arm(8'hA5, 8'h3C, 8'h0F);
        send_word(8'hA5, 0);
        wait_idx(6);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send_word(8'h3C, 0);
        send_word(8'h0F, 0);
        end_checks(0, 1'b0);
        check_seq("seq_start_ignored", SEQ_A);

`ifdef CCFF_READBACK_EN
        // Stuck-at-0 on chain bit 5 must be reported
        stuck5 = 1'b1;
        pulse_start();
        arm(8'hA5, 8'h3C, 8'h0F);
        send_word(8'hA5, 0);
        send_word(8'h3C, 0);
        send_word(8'h0F, 0);
        end_checks(0, 1'b1);
        check("done_with_err", done, 1);
        stuck5 = 1'b0;
`endif

        // Reload from DONE with all-ones words
        pulse_start();
        check("err_cleared_at_start", err, 0);
        check("done_cleared_at_start", done, 0);
        arm(8'hFF, 8'hFF, 8'hFF);
        send_word(8'hFF, 0);
        send_word(8'hFF, 0);
        send_word(8'hFF, 0);
        end_checks(0, 1'b0);
        check_seq("seq_all_ones", 20'hFFFFF);
        check_chain(20'hFFFFF);

        model_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
